// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and latency limits for
// the system RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic REQ_CPU     = 1'b0;
    localparam logic REQ_DMA     = 1'b1;
    localparam int   MAX_MEM_LAT = 7;

    // Terminal value of the WAIT counter: WAIT lasts MEM_LAT-1 cycles, and
    // the counter starts at 0. Unused (and clamped) when MEM_LAT is 1.
    function automatic logic [2:0] wait_last(input int lat);
        int l;
        l = (lat > MAX_MEM_LAT) ? MAX_MEM_LAT : lat;
        return (l < 2) ? 3'd0 : 3'(l - 2);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: winner select between the CPU and DMA ports.
// With ARB_ROUND_ROBIN_EN defined, a one-bit last-winner pointer breaks ties
// in favour of the port not granted last; otherwise CPU has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic elig_cpu,
    input  logic elig_dma,
    input  logic take,      // a grant is being made this cycle
    output logic valid,
    output logic winner
);

    assign valid = elig_cpu | elig_dma;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    // On a tie the port that did not win last time gets the grant
    always_comb begin
        winner = REQ_CPU;
        if (elig_cpu && elig_dma)
            winner = ~last;
        else if (elig_dma)
            winner = REQ_DMA;
    end

    // Track the last winner; reset to DMA-last so the first tie goes to CPU
    always_ff @(posedge clk) begin
        if (!reset_n)
            last <= REQ_DMA;
        else if (take)
            last <= winner;
    end
`else
    logic unused_rr;
    assign unused_rr = clk ^ reset_n ^ take;

    // Fixed priority, CPU over DMA
    always_comb begin
        winner = elig_cpu ? REQ_CPU : REQ_DMA;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single synchronous system RAM between the CPU
// memory interface and the DMA/program-loader port. One transaction at a
// time: IDLE -> ISSUE (one mem_en strobe) -> WAIT (MEM_LAT-1 cycles) -> RESP,
// then a one-cycle done pulse to the owner. Optional macro
// ARB_ROUND_ROBIN_EN switches arbitration from fixed CPU priority to
// round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] WAIT_LAST = wait_last(MEM_LAT);

    state_t            state, state_nx;
    logic [2:0]        wait_cnt;
    logic              cmd_id, cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              elig_cpu, elig_dma, pick_vld, pick_id;
    logic              grant, finish;

    // A port is skipped in its own done cycle, giving it one turnaround cycle
    assign elig_cpu = cpu_req & ~cpu_done;
    assign elig_dma = dma_req & ~dma_done;

    arb_pick u_pick (
        .clk      (clk),
        .reset_n  (reset_n),
        .elig_cpu (elig_cpu),
        .elig_dma (elig_dma),
        .take     (grant),
        .valid    (pick_vld),
        .winner   (pick_id)
    );

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = (MEM_LAT > 1) ? WAIT : RESP;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nx = RESP;
            RESP: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and WAIT cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    // Command latch, grant/done flags and per-port read-data hold registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_id    <= REQ_CPU;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            dma_done  <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            if (grant) begin
                cmd_id    <= pick_id;
                cmd_we    <= (pick_id == REQ_DMA) ? dma_we    : cpu_we;
                cmd_addr  <= (pick_id == REQ_DMA) ? dma_addr  : cpu_addr;
                cmd_wdata <= (pick_id == REQ_DMA) ? dma_wdata : cpu_wdata;
                cpu_gnt   <= (pick_id == REQ_CPU);
                dma_gnt   <= (pick_id == REQ_DMA);
            end
            if (finish) begin
                cpu_gnt  <= 1'b0;
                dma_gnt  <= 1'b0;
                cpu_done <= (cmd_id == REQ_CPU);
                dma_done <= (cmd_id == REQ_DMA);
                if (!cmd_we) begin
                    if (cmd_id == REQ_CPU)
                        cpu_rdata <= mem_rdata;
                    else
                        dma_rdata <= mem_rdata;
                end
            end
        end
    end

    // RAM command: single strobe in ISSUE, address/data held from the latch
    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-timeline model of the arbiter. Honours
// ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int LAT    = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic [1:0] req, we;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic cpu_gnt, dma_gnt, cpu_done, dma_done;
    logic [DATA_W-1:0] cpu_rdata, dma_rdata;
    logic mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0] gnt, dn;
    logic [1:0][DATA_W-1:0] rd;

    logic poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [DATA_W-1:0] poke_data = '0;

    int checks = 0;
    int fails  = 0;

    assign gnt = {dma_gnt, cpu_gnt};
    assign dn  = {dma_done, cpu_done};
    assign rd  = {dma_rdata, cpu_rdata};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(req[1]), .dma_we(we[1]), .dma_addr(addr[1]), .dma_wdata(wdata[1]),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // ---------------- RAM environment: LAT-cycle read pipeline ----------------
    logic [DATA_W-1:0] ram [512];
    logic [DATA_W-1:0] rd_pipe [LAT];
    bit ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (poke_en) ram[poke_addr] <= poke_data;
            if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= mem_en ? ram[mem_addr] : $urandom();
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // ---------------- Behavioural model ----------------
    // A transaction is a timeline: the grant decision is step 0, the RAM strobe
    // is step 1, the result is ready after step LAT+1, done follows.
    bit m_init = 1'b0;
    bit m_busy, m_owner, m_we, m_last;
    int m_k;
    bit [1:0] m_done;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata [2];
    logic [DATA_W-1:0] mref [512];

    always @(posedge clk) begin
        bit [1:0] elig;
        bit w;
        if (!m_init) begin
            for (int i = 0; i < 512; i++) mref[i] = init_word(i);
            m_init = 1'b1;
        end
        if (poke_en) mref[poke_addr] = poke_data;
        // a write strobed this cycle lands even if reset is sampled now
        if (m_busy && m_k == 1 && m_we) mref[m_addr] = m_wdata;
        if (!reset_n) begin
            m_busy = 1'b0; m_k = 0; m_done = 2'b00; m_owner = 1'b0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_last = 1'b1;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
            elig   = req & ~m_done;
            m_done = 2'b00;
            if (m_busy) begin
                if (m_k == LAT + 1) begin
                    m_done[m_owner] = 1'b1;
                    if (!m_we) m_rdata[m_owner] = mref[m_addr];
                    m_busy = 1'b0;
                end else begin
                    m_k++;
                end
            end else if (elig != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (elig == 2'b11) w = ~m_last;
                else               w = elig[1];
                m_last = w;
`else
                w = !elig[0];
`endif
                m_owner = w; m_busy = 1'b1; m_k = 1;
                m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w];
            end
        end
    end

    // ---------------- Checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic men;
        men = m_busy && m_k == 1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt[%0d]", i), 32'(gnt[i]), 32'(m_busy && int'(m_owner) == i));
            chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
            chk($sformatf("rdata[%0d]", i), rd[i], m_rdata[i]);
        end
        chk("mem_en", 32'(mem_en), 32'(men));
        chk("mem_we", 32'(mem_we), 32'(men && m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic new_cmd(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(1));
        addr[p]  = ADDR_W'($urandom_range(15));
        wdata[p] = $urandom();
    endtask

    task automatic wait_done(input int p, input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dn[p] && n < limit);
        chk($sformatf("done_within_limit[%0d]", p), 32'(dn[p]), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp2;
        reset_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
        @(posedge clk); @(negedge clk);
        tick();
        reset_n   = 1'b1;
        poke_en   = 1'b1; poke_addr = 9'h010; poke_data = 32'hDEADBEEF;
        tick();
        poke_en = 1'b0;

        // reset state
        chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
        chk("rst_dma_done", 32'(dma_done), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);

        // CPU read alone: mem_en in cycle 1, done in cycle LAT+2 = 5
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'h010;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("rd1_cpu_done", 32'(cpu_done), 32'(c == 5));
            chk("rd1_dma_gnt", 32'(dma_gnt), 0);
            chk("rd1_mem_en", 32'(mem_en), 32'(c == 1));
            if (c == 1) chk("rd1_mem_addr", 32'(mem_addr), 32'h010);
            if (c == 5) begin
                chk("rd1_model_done", 32'(m_done), 32'd1);
                chk("rd1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
                req[0] = 1'b0;
            end
        end

        // DMA write, then CPU read of the same word
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 9'h020; wdata[1] = 32'h12345678;
        tick();
        chk("wr_dma_gnt", 32'(dma_gnt), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        wait_done(1, 10);
        req[1] = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'h020;
        wait_done(0, 10);
        req[0] = 1'b0;
        chk("wr_cpu_rdata", cpu_rdata, 32'h12345678);
        chk("wr_dma_rdata", dma_rdata, 32'h0);
        chk("wr_model_mref", mref[9'h020], 32'h12345678);

        // Both hold req from a fresh reset: CPU, DMA, CPU, DMA at 5,10,15,20
        do_reset();
        req = 2'b11; we = 2'b00; addr[0] = 9'h010; addr[1] = 9'h020;
        for (int c = 1; c <= 23; c++) begin
            tick();
            exp2 = (c == 5 || c == 15) ? 2'b01 : (c == 10 || c == 20) ? 2'b10 : 2'b00;
            chk("alt_done", 32'(dn), 32'(exp2));
            if (c == 10) chk("alt_model_done", 32'(m_done), 32'd2);
            if (c == 20) req = 2'b00;
        end
        chk("alt_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("alt_dma_rdata", dma_rdata, 32'h12345678);

        // CPU read, idle 2 cycles, then a tie
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'h010;
        wait_done(0, 10);
        req[0] = 1'b0;
        tick(); tick();
        req = 2'b11; we = 2'b00;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie_gnt", 32'(gnt), 32'd2);
`else
        chk("tie_gnt", 32'(gnt), 32'd1);
`endif
        for (int c = 0; c < 14; c++) begin
            tick();
            if (dn[0]) req[0] = 1'b0;
            if (dn[1]) req[1] = 1'b0;
        end
        chk("tie_both_served", 32'(req), 0);

        // Reset during WAIT aborts the read; a fresh read takes 5 cycles
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'h010;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("abort_cpu_gnt", 32'(cpu_gnt), 0);
        chk("abort_cpu_done", 32'(cpu_done), 0);
        chk("abort_mem_en", 32'(mem_en), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_cpu_rdata", cpu_rdata, 0);
        reset_n = 1'b1; req[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abort_no_done", 32'(cpu_done), 0);
        end
        req[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("fresh_cpu_done", 32'(cpu_done), 32'(c == 5));
            if (c == 5) begin
                chk("fresh_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
                req[0] = 1'b0;
            end
        end

        // CPU holds req through done: no grant in done cycle, next done 6 later
        req[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("hold_cpu_done", 32'(cpu_done), 32'(c == 5 || c == 11));
            if (c == 5 || c == 6) chk("hold_cpu_gnt", 32'(cpu_gnt), 0);
            if (c == 11) req[0] = 1'b0;
        end

        // Randomized traffic with occasional resets and early req drops
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!req[p]) begin
                    if (!gnt[p] && $urandom_range(3) == 0) new_cmd(p);
                end else if (dn[p]) begin
                    if ($urandom_range(1) == 1) new_cmd(p);
                    else req[p] = 1'b0;
                end else if (gnt[p] && $urandom_range(63) == 0) begin
                    req[p] = 1'b0;
                end
            end
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(299) == 0) reset_n = 1'b0;
        end
        req = 2'b00; reset_n = 1'b1;
        for (int c = 0; c < 12; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single synchronous system RAM. It shares the RAM between the CPU memory interface (MAR/MDR path driven by the control unit's read/write strobes) and a DMA/program-loader port. It serialises requests, drives the RAM command for a fixed latency and returns read data with a one-cycle done pulse to the winning requester.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- MEM_LAT, 1, RAM read latency in cycles; legal values 1..7
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_req / dma_req  in  1  request; held with stable command until done
- cpu_we / dma_we  in  1  1 = write, 0 = read
- cpu_addr / dma_addr  in  ADDR_W  word address
- cpu_wdata / dma_wdata  in  DATA_W  write data
- cpu_gnt / dma_gnt  out  1  transaction owned by this port
- cpu_done / dma_done  out  1  one-cycle completion pulse
- cpu_rdata / dma_rdata  out  DATA_W  per-port read-data hold register
- mem_en  out  1  RAM access strobe, one cycle per transaction
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate among eligible requests. A port whose done is high this cycle is ineligible (one-cycle turnaround). With a winner, latch we/addr/wdata/id, set its gnt, go to ISSUE. Otherwise stay.
- ISSUE: mem_en=1, with mem_we/addr/wdata taken from the latched command. Go to WAIT if MEM_LAT>1, else RESP.
- WAIT: a 3-bit counter counts MEM_LAT-1 cycles, then goes to RESP.
- RESP: mem_rdata is valid. On a read, the winner's rdata register loads mem_rdata at the closing edge. The winner's done register sets, gnt clears, and the FSM returns to IDLE.
- Writes follow the same sequence. The rdata registers are unchanged on a write.
- Protocol violation: if req drops while gnt is high, the transaction still completes and done still pulses.
- mem_addr/mem_wdata/mem_we are only meaningful when mem_en=1. Hold them at the latched values.
- Arbitration without the macro: fixed priority, CPU over DMA.

## Timing
- Reset (the cycle after reset_n sampled low): state IDLE, all gnt/done/mem_en/mem_we 0, mem_addr/mem_wdata 0, rdata registers 0, RR pointer = DMA-last.
- Reset mid-transaction aborts it. No done is issued. A write already strobed into the RAM is not undone.
- A request sampled in IDLE at cycle t produces:
  - gnt high during t+1 .. t+1+MEM_LAT
  - mem_en during t+1
  - RESP at t+1+MEM_LAT
  - done and valid rdata at t+2+MEM_LAT
  - latency MEM_LAT+2
- The done cycle is an IDLE cycle. The other port may win in it. The same port can win earliest at done+1.
- A requester deasserts or changes req on the edge after it sees done.
- rdata holds until that port's next read completes.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a one-bit last-winner pointer updates at every grant. On simultaneous eligible requests, the port not granted last wins. The pointer resets to DMA-last, so the first tie goes to CPU.
- ARB_ROUND_ROBIN_EN undefined: fixed CPU priority. The pointer logic is removed.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester IDs REQ_CPU=0, REQ_DMA=1
  - MAX_MEM_LAT=7
- One sub-module, arb_pick: combinational winner select from two eligible bits and the pointer, plus the registered pointer under the macro.
- FSM, command latch and rdata registers live in mem_arbiter.

## Test plan
- CPU read alone, MEM_LAT=1, RAM[0x010]=0xDEADBEEF, cpu_req at cycle 0 -> mem_en at cycle 1 with addr 0x010; cpu_done at cycle 3 only; cpu_rdata=0xDEADBEEF; dma_gnt stays 0.
- DMA write 0x020 ← 0x12345678, then CPU read 0x020 -> cpu_rdata=0x12345678; dma_rdata unchanged.
- Both ports hold req continuously, MEM_LAT=1 -> grants alternate CPU, DMA, CPU…; done pulses at cycles 3, 6, 9, 12.
- CPU read completes; idle 2 cycles; then both raise req together -> with ARB_ROUND_ROBIN_EN the DMA wins, without it the CPU wins.
- MEM_LAT=3, CPU read issued; reset_n low for one cycle during WAIT -> next cycle all outputs 0, no cpu_done, cpu_rdata=0; a fresh request afterwards completes normally in 5 cycles.
- CPU holds req through done, MEM_LAT=1 -> no grant in the done cycle; second done exactly 4 cycles after the first.
